mips_mc_control: RTL

- Multicycle MIPS control unit: a Moore FSM plus opcode/funct decode.
- Drives every control input of the multicycle datapath from its `instr` and `zero` outputs; this is the other end of the datapath control interface.
- One instruction completes every 3–5 cycles.
- Also generates `memwrite` for the unified instruction/data memory.

---
 rtl/mips_mc_pkg.sv | 59 +++++
 rtl/mips_mc_control_if.sv | 37 +++
 rtl/mips_alu_decoder.sv | 51 +++++
 rtl/mips_mc_control.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Opcodes, functs, ALU codes, FSM states and datapath mux selects.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control/status bundle between the multicycle controller and datapath.
// master = controller side, slave = datapath side.
interface mips_mc_control_if #(
    parameter int STATE_W = 4
);
    logic [31:0]        instr;
    logic               zero;
    logic               pcen;
    logic [1:0]         pcsrc;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [2:0]         alucontrol;
    logic               iord;
    logic               irwrite;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic               memwrite;
    logic               bne_sign;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  instr, zero,
        output pcen, pcsrc, alusrca, alusrcb, alucontrol,
        output iord, irwrite, regwrite, regdst, memtoreg,
        output memwrite, bne_sign, illegal_op, state_dbg
    );

    modport slave (
        output instr, zero,
        input  pcen, pcsrc, alusrca, alusrcb, alucontrol,
        input  iord, irwrite, regwrite, regdst, memtoreg,
        input  memwrite, bne_sign, illegal_op, state_dbg
    );

endinterface

// File: rtl/mips_alu_decoder.sv
// ALU decoder: aluop selects add, sub or funct-driven operation.
// funct_valid flags a supported R-type funct regardless of aluop.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    logic [2:0] funct_alu;

    always_comb begin
        funct_alu   = ALU_ADD;
        funct_valid = 1'b0;
        case (funct)
            F_ADD: begin
                funct_alu   = ALU_ADD;
                funct_valid = 1'b1;
            end
            F_SUB: begin
                funct_alu   = ALU_SUB;
                funct_valid = 1'b1;
            end
            F_AND: begin
                funct_alu   = ALU_AND;
                funct_valid = 1'b1;
            end
            F_OR: begin
                funct_alu   = ALU_OR;
                funct_valid = 1'b1;
            end
            F_SLT: begin
                funct_alu   = ALU_SLT;
                funct_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_alu;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS controller: Moore FSM over the instruction register.
// Only pcen mixes in the live zero flag; reset masks every output.
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    mips_mc_control_if.master ctl
);

    localparam logic [STATE_W-1:0] FETCH   = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] DECODE  = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(S_MEMADR);
    localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(S_MEMRD);
    localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(S_MEMWB);
    localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(S_MEMWR);
    localparam logic [STATE_W-1:0] EXECUTE = STATE_W'(S_EXECUTE);
    localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(S_ALUWB);
    localparam logic [STATE_W-1:0] BRANCH  = STATE_W'(S_BRANCH);
    localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(S_ADDIEX);
    localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(S_ADDIWB);
    localparam logic [STATE_W-1:0] JUMP    = STATE_W'(S_JUMP);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;

    logic [5:0] op;
    logic [5:0] funct;
    logic       funct_valid;
    logic [2:0] alu_dec;

    logic       pcwrite;
    logic       branch;
    logic       bne_sign;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       iord;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       memwrite;
    logic       illegal;

    assign op    = opcode_of(ctl.instr);
    assign funct = funct_of(ctl.instr);

    mips_alu_decoder u_alu_dec (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (alu_dec),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne_sign = 1'b0;
        pcsrc    = PCSRC_ALU;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        aluop    = ALUOP_ADD;
        iord     = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        memwrite = 1'b0;
        illegal  = 1'b0;
        case (state)
            FETCH: begin
                irwrite  = 1'b1;
                alusrcb  = SRCB_FOUR;
                pcwrite  = 1'b1;
                state_nx = DECODE;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_RTYPE:     state_nx = EXECUTE;
                    OP_BEQ:       state_nx = BRANCH;
                    OP_BNE: begin
                        if (SUPPORT_BNE) begin
                            state_nx = BRANCH;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_ADDI:      state_nx = ADDIEX;
                    OP_J:         state_nx = JUMP;
                    default:      illegal  = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                state_nx = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord     = 1'b1;
                state_nx = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                if (funct_valid) begin
                    state_nx = ALUWB;
                end else begin
                    illegal = 1'b1;
                end
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                branch   = 1'b1;
                bne_sign = (op == OP_BNE);
            end
            ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                state_nx = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset aborts the instruction: every decoded output falls to its default.
    assign ctl.pcen       = ~rst & (pcwrite | (branch & (ctl.zero ^ bne_sign)));
    assign ctl.pcsrc      = rst ? PCSRC_ALU : pcsrc;
    assign ctl.alusrca    = ~rst & alusrca;
    assign ctl.alusrcb    = rst ? SRCB_REG : alusrcb;
    assign ctl.alucontrol = rst ? ALU_ADD : alu_dec;
    assign ctl.iord       = ~rst & iord;
    assign ctl.irwrite    = ~rst & irwrite;
    assign ctl.regwrite   = ~rst & regwrite;
    assign ctl.regdst     = ~rst & regdst;
    assign ctl.memtoreg   = ~rst & memtoreg;
    assign ctl.memwrite   = ~rst & memwrite;
    assign ctl.bne_sign   = ~rst & bne_sign;
    assign ctl.illegal_op = ~rst & illegal;
    assign ctl.state_dbg  = state;

endmodule
